iob_axil2iob_nsplit: RTL and testbench

IOB_AXIL2IOB_NSPLIT -- requirements
Module: iob_axil2iob_nsplit

---
 rtl/iob_axil2iob_nsplit_pkg.sv | 22 ++
 rtl/iob_axil2iob_nsplit_timeout.sv | 40 ++++
 rtl/iob_axil2iob_nsplit.sv | 212 +++++++++++++++++++++
 tb/tb_iob_axil2iob_nsplit.sv | 564 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_axil2iob_nsplit_pkg.sv
// Shared definitions for the AXI4-Lite to split IOb bridge:
// FSM encoding, AXI response codes and select-width helper.
package iob_axil2iob_nsplit_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_REQ  = 3'd1;
   localparam logic [2:0] ST_WR_RESP = 3'd2;
   localparam logic [2:0] ST_RD_REQ  = 3'd3;
   localparam logic [2:0] ST_RD_WAIT = 3'd4;
   localparam logic [2:0] ST_RD_RESP = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic int sel_w(input int n);
      int c;
      c = $clog2(n);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/iob_axil2iob_nsplit_timeout.sv
// Saturating timeout counter: cleared while idle, counts while
// enabled and flags expiry at the all-ones value.
module iob_timeout_cnt
   import iob_axil2iob_nsplit_pkg::*;
#(
   parameter int TIMEOUT_W = 8
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic cke_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [TIMEOUT_W-1:0] cnt_q;
   logic [TIMEOUT_W-1:0] cnt_d;

   assign expired_o = &cnt_q;

   // next count: clear wins, then saturating increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // count register, reset independent of clock enable
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (cke_i) begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/iob_axil2iob_nsplit.sv
// AXI4-Lite slave to N-way IOb master bridge, one transaction
// in flight, round-robin write/read arbitration with timeout.
module iob_axil2iob_nsplit
   import iob_axil2iob_nsplit_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int N_SLAVES  = 4,
   parameter int P_SLAVES  = ADDR_W - 3,
   parameter int TIMEOUT_W = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         cke_i,
   input  logic [ADDR_W-1:0]            axil_awaddr_i,
   input  logic [2:0]                   axil_awprot_i,
   input  logic                         axil_awvalid_i,
   output logic                         axil_awready_o,
   input  logic [DATA_W-1:0]            axil_wdata_i,
   input  logic [DATA_W/8-1:0]          axil_wstrb_i,
   input  logic                         axil_wvalid_i,
   output logic                         axil_wready_o,
   output logic [1:0]                   axil_bresp_o,
   output logic                         axil_bvalid_o,
   input  logic                         axil_bready_i,
   input  logic [ADDR_W-1:0]            axil_araddr_i,
   input  logic [2:0]                   axil_arprot_i,
   input  logic                         axil_arvalid_i,
   output logic                         axil_arready_o,
   output logic [DATA_W-1:0]            axil_rdata_o,
   output logic [1:0]                   axil_rresp_o,
   output logic                         axil_rvalid_o,
   input  logic                         axil_rready_i,
   output logic [N_SLAVES-1:0]          iob_avalid_o,
   output logic [ADDR_W-1:0]            iob_addr_o,
   output logic [DATA_W-1:0]            iob_wdata_o,
   output logic [DATA_W/8-1:0]          iob_wstrb_o,
   input  logic [N_SLAVES-1:0]          iob_ready_i,
   input  logic [N_SLAVES-1:0]          iob_rvalid_i,
   input  logic [N_SLAVES*DATA_W-1:0]   iob_rdata_i,
   output logic                         timeout_o
);

   localparam int SEL_W = sel_w(N_SLAVES);

   logic [2:0]            state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [1:0]            resp_q, resp_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic                  prio_wr_q, prio_wr_d;

   logic [SEL_W-1:0]      aw_sel, ar_sel;
   logic                  aw_dec, ar_dec;
   logic [N_SLAVES-1:0]   sel_oh;
   logic [DATA_W-1:0]     rdata_sel;
   logic                  ready_sel, rvalid_sel;
   logic                  idle, req_st, cnt_en, expired;
   logic                  grant_wr, grant_rd;
   logic                  unused_prot;

   assign unused_prot = ^{axil_awprot_i, axil_arprot_i};

   assign aw_sel = axil_awaddr_i[P_SLAVES -: SEL_W];
   assign ar_sel = axil_araddr_i[P_SLAVES -: SEL_W];
   assign aw_dec = 32'(aw_sel) >= N_SLAVES;
   assign ar_dec = 32'(ar_sel) >= N_SLAVES;

   // one-hot decode of the registered select and read-data mux
   always_comb begin
      sel_oh    = '0;
      rdata_sel = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         sel_oh[k] = (32'(sel_q) == k);
         if (32'(sel_q) == k) begin
            rdata_sel = iob_rdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign ready_sel  = |(iob_ready_i & sel_oh);
   assign rvalid_sel = |(iob_rvalid_i & sel_oh);

   assign idle   = (state_q == ST_IDLE);
   assign req_st = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
   assign cnt_en = req_st || (state_q == ST_RD_WAIT);

   assign grant_wr = cke_i & idle & axil_awvalid_i & axil_wvalid_i
                   & (prio_wr_q | ~axil_arvalid_i);
   assign grant_rd = cke_i & idle & axil_arvalid_i & ~grant_wr;

   iob_timeout_cnt #(
      .TIMEOUT_W (TIMEOUT_W)
   ) u_tmo (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .cke_i     (cke_i),
      .clr_i     (~cnt_en),
      .en_i      (cnt_en),
      .expired_o (expired)
   );

   // transaction FSM and captured request/response fields
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      sel_d     = sel_q;
      resp_d    = resp_q;
      rdata_d   = rdata_q;
      prio_wr_d = prio_wr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grant_wr) begin
               addr_d    = axil_awaddr_i;
               wdata_d   = axil_wdata_i;
               wstrb_d   = axil_wstrb_i;
               sel_d     = aw_sel;
               prio_wr_d = 1'b0;
               resp_d    = aw_dec ? RESP_DECERR : RESP_OKAY;
               state_d   = aw_dec ? ST_WR_RESP : ST_WR_REQ;
            end else if (grant_rd) begin
               addr_d    = axil_araddr_i;
               wstrb_d   = '0;
               sel_d     = ar_sel;
               prio_wr_d = 1'b1;
               rdata_d   = '0;
               resp_d    = ar_dec ? RESP_DECERR : RESP_OKAY;
               state_d   = ar_dec ? ST_RD_RESP : ST_RD_REQ;
            end
         end
         ST_WR_REQ: begin
            if (expired) begin
               resp_d  = RESP_SLVERR;
               state_d = ST_WR_RESP;
            end else if (ready_sel) begin
               resp_d  = RESP_OKAY;
               state_d = ST_WR_RESP;
            end
         end
         ST_RD_REQ: begin
            if (expired) begin
               resp_d  = RESP_SLVERR;
               rdata_d = '0;
               state_d = ST_RD_RESP;
            end else if (ready_sel) begin
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (expired) begin
               resp_d  = RESP_SLVERR;
               rdata_d = '0;
               state_d = ST_RD_RESP;
            end else if (rvalid_sel) begin
               resp_d  = RESP_OKAY;
               rdata_d = rdata_sel;
               state_d = ST_RD_RESP;
            end
         end
         ST_WR_RESP: begin
            if (axil_bready_i) state_d = ST_IDLE;
         end
         ST_RD_RESP: begin
            if (axil_rready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state registers, reset independent of clock enable
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         sel_q     <= '0;
         resp_q    <= RESP_OKAY;
         rdata_q   <= '0;
         prio_wr_q <= 1'b1;
      end else if (cke_i) begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         sel_q     <= sel_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
         prio_wr_q <= prio_wr_d;
      end
   end

   assign axil_awready_o = grant_wr;
   assign axil_wready_o  = grant_wr;
   assign axil_arready_o = grant_rd;
   assign axil_bvalid_o  = (state_q == ST_WR_RESP);
   assign axil_bresp_o   = (state_q == ST_WR_RESP) ? resp_q : RESP_OKAY;
   assign axil_rvalid_o  = (state_q == ST_RD_RESP);
   assign axil_rresp_o   = (state_q == ST_RD_RESP) ? resp_q : RESP_OKAY;
   assign axil_rdata_o   = rdata_q;

   assign iob_avalid_o = (req_st && !expired) ? sel_oh : '0;
   assign iob_addr_o   = addr_q;
   assign iob_wdata_o  = wdata_q;
   assign iob_wstrb_o  = wstrb_q;
   assign timeout_o    = cnt_en & expired & cke_i;

endmodule

// File: tb/tb_iob_axil2iob_nsplit.sv
// Bench for iob_axil2iob_nsplit: 4-slave and 3-slave instances,
// scoreboard of expected AXI responses, per-scenario tasks.
module tb_iob_axil2iob_nsplit;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 4;
   localparam int TW = 4;

   typedef struct packed {
      logic        wr;
      logic [1:0]  resp;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, cke;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0] awprot, arprot;
   logic awvalid, wvalid, bready, arvalid, rready;
   logic [DW-1:0] wdata;
   logic [DW/8-1:0] wstrb;
   logic [NS-1:0] iready, irvalid;
   logic [NS*DW-1:0] irdata;

   logic awready, wready, bvalid, arready, rvalid, tmo;
   logic [1:0] bresp, rresp;
   logic [DW-1:0] rdata, iwdata;
   logic [AW-1:0] iaddr;
   logic [DW/8-1:0] iwstrb;
   logic [NS-1:0] avalid;

   logic awready3, wready3, bvalid3, arready3, rvalid3, tmo3;
   logic [1:0] bresp3, rresp3;
   logic [DW-1:0] rdata3, iwdata3;
   logic [AW-1:0] iaddr3;
   logic [DW/8-1:0] iwstrb3;
   logic [2:0] avalid3;

   iob_axil2iob_nsplit #(
      .ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS), .TIMEOUT_W(TW)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke),
      .axil_awaddr_i(awaddr), .axil_awprot_i(awprot),
      .axil_awvalid_i(awvalid), .axil_awready_o(awready),
      .axil_wdata_i(wdata), .axil_wstrb_i(wstrb),
      .axil_wvalid_i(wvalid), .axil_wready_o(wready),
      .axil_bresp_o(bresp), .axil_bvalid_o(bvalid),
      .axil_bready_i(bready),
      .axil_araddr_i(araddr), .axil_arprot_i(arprot),
      .axil_arvalid_i(arvalid), .axil_arready_o(arready),
      .axil_rdata_o(rdata), .axil_rresp_o(rresp),
      .axil_rvalid_o(rvalid), .axil_rready_i(rready),
      .iob_avalid_o(avalid), .iob_addr_o(iaddr),
      .iob_wdata_o(iwdata), .iob_wstrb_o(iwstrb),
      .iob_ready_i(iready), .iob_rvalid_i(irvalid),
      .iob_rdata_i(irdata), .timeout_o(tmo)
   );

   iob_axil2iob_nsplit #(
      .ADDR_W(AW), .DATA_W(DW), .N_SLAVES(3), .TIMEOUT_W(TW)
   ) dut3 (
      .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke),
      .axil_awaddr_i(awaddr), .axil_awprot_i(awprot),
      .axil_awvalid_i(awvalid), .axil_awready_o(awready3),
      .axil_wdata_i(wdata), .axil_wstrb_i(wstrb),
      .axil_wvalid_i(wvalid), .axil_wready_o(wready3),
      .axil_bresp_o(bresp3), .axil_bvalid_o(bvalid3),
      .axil_bready_i(bready),
      .axil_araddr_i(araddr), .axil_arprot_i(arprot),
      .axil_arvalid_i(arvalid), .axil_arready_o(arready3),
      .axil_rdata_o(rdata3), .axil_rresp_o(rresp3),
      .axil_rvalid_o(rvalid3), .axil_rready_i(rready),
      .iob_avalid_o(avalid3), .iob_addr_o(iaddr3),
      .iob_wdata_o(iwdata3), .iob_wstrb_o(iwstrb3),
      .iob_ready_i(iready[2:0]), .iob_rvalid_i(irvalid[2:0]),
      .iob_rdata_i(irdata[3*DW-1:0]), .timeout_o(tmo3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      awaddr = '0; awprot = '0; awvalid = 0;
      wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
      araddr = '0; arprot = '0; arvalid = 0; rready = 0;
      iready = '0; irvalid = '0; irdata = '0;
   endtask

   task automatic apply_reset();
      rst_n = 0;
      cke = 1;
      idle_inputs();
      step();
      step();
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0; cke = 0; idle_inputs();
      awvalid = 1; wvalid = 1; arvalid = 1;
      iready = '1; irvalid = '1; irdata = '1;
      step(); step(); smp();
      n_chk++;
      if ({awready, wready, bvalid, bresp, arready, rvalid, rresp,
           rdata, avalid, iaddr, iwdata, iwstrb, tmo} !== '0) begin
         n_fail++;
         $display("FAIL reset_outs: got bv=%b rv=%b av=%b addr=%h want all 0",
                  bvalid, rvalid, avalid, iaddr);
      end
      n_chk++;
      if ({awready3, bvalid3, arready3, rvalid3, rdata3,
           avalid3, iaddr3, tmo3} !== '0) begin
         n_fail++;
         $display("FAIL reset_outs3: got bv=%b rv=%b av=%b want all 0",
                  bvalid3, rvalid3, avalid3);
      end
      step();
      rst_n = 1; cke = 1; idle_inputs();
      smp();
      n_chk++;
      if ({awready, arready, bvalid, rvalid, avalid, tmo} !== '0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got aw=%b ar=%b bv=%b rv=%b want 0",
                  awready, arready, bvalid, rvalid);
      end
      step();
   endtask

   task automatic test_write();
      exp_t e;
      awaddr = 32'h1000_0004; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      awvalid = 1; wvalid = 1; iready = 4'b0010;
      smp();
      n_chk++;
      if ({awready, wready, arready} !== 3'b110) begin
         n_fail++;
         $display("FAIL wr_accept: got %b want 110",
                  {awready, wready, arready});
      end
      sb.push_back({1'b1, 2'b00, 32'h0});
      step(); awvalid = 0; wvalid = 0; smp();
      n_chk++;
      if (avalid !== 4'b0010 || iaddr !== 32'h1000_0004 ||
          iwdata !== 32'hDEAD_BEEF || iwstrb !== 4'hF) begin
         n_fail++;
         $display("FAIL wr_iob: got av=%b a=%h d=%h s=%h want 0010 10000004 deadbeef f",
                  avalid, iaddr, iwdata, iwstrb);
      end
      step(); bready = 1; smp();
      n_chk++;
      if (avalid !== 4'b0000 || bvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_latency: got av=%b bv=%b want 0000 1", avalid, bvalid);
      end
      if (bvalid && bready && sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (!e.wr || bresp !== e.resp) begin
            n_fail++;
            $display("FAIL wr_bresp: got %b want %b", bresp, e.resp);
         end
      end
      step(); bready = 0; iready = 0; smp();
      n_chk++;
      if (bvalid !== 1'b0 || awready !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_done: got bv=%b aw=%b want 0 0", bvalid, awready);
      end
      step();
   endtask

   task automatic test_read();
      exp_t e;
      araddr = 32'h3000_0010; arvalid = 1;
      smp();
      n_chk++;
      if ({arready, awready} !== 2'b10) begin
         n_fail++;
         $display("FAIL rd_accept: got %b want 10", {arready, awready});
      end
      sb.push_back({1'b0, 2'b00, 32'h1234_5678});
      step(); arvalid = 0; smp();
      n_chk++;
      if (avalid !== 4'b1000 || iwstrb !== 4'h0 || iaddr !== 32'h3000_0010) begin
         n_fail++;
         $display("FAIL rd_iob: got av=%b s=%h a=%h want 1000 0 30000010",
                  avalid, iwstrb, iaddr);
      end
      step(); smp();
      step(); iready = 4'b1000; irvalid = 4'b1000;
      irdata[3*DW +: DW] = 32'hBAD0_BAD0; smp();
      step(); iready = 0; irvalid = 4'b1001;
      irdata[3*DW +: DW] = 32'h1234_5678;
      irdata[0 +: DW] = 32'hFFFF_0000; smp();
      n_chk++;
      if (avalid !== 4'b0000 || rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_wait: got av=%b rv=%b want 0000 0", avalid, rvalid);
      end
      step(); irvalid = 0; irdata = '1; smp();
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            step(); smp();
         end
         n_chk++;
         if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || rresp !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_hold%0d: got rv=%b d=%h r=%b want 1 12345678 00",
                     i, rvalid, rdata, rresp);
         end
      end
      step(); rready = 1; smp();
      if (rvalid && rready && sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (e.wr || rresp !== e.resp || rdata !== e.data) begin
            n_fail++;
            $display("FAIL rd_resp: got %b %h want %b %h",
                     rresp, rdata, e.resp, e.data);
         end
      end
      step(); rready = 0; smp();
      n_chk++;
      if (rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_done: got rv=%b want 0", rvalid);
      end
      step(); irdata = '0;
   endtask

   task automatic test_decerr();
      exp_t e;
      apply_reset();
      araddr = 32'h3000_0000; arvalid = 1;
      smp();
      n_chk++;
      if (arready3 !== 1'b1) begin
         n_fail++;
         $display("FAIL dec_rd_accept: got %b want 1", arready3);
      end
      sb.push_back({1'b0, 2'b11, 32'h0});
      step(); arvalid = 0; rready = 1; irdata = '1; smp();
      n_chk++;
      if (avalid3 !== 3'b000 || rvalid3 !== 1'b1) begin
         n_fail++;
         $display("FAIL dec_rd_direct: got av=%b rv=%b want 000 1",
                  avalid3, rvalid3);
      end
      if (rvalid3 && rready && sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (e.wr || rresp3 !== e.resp || rdata3 !== e.data) begin
            n_fail++;
            $display("FAIL dec_rd_resp: got %b %h want %b %h",
                     rresp3, rdata3, e.resp, e.data);
         end
      end
      step(); rready = 0;
      awaddr = 32'h3000_0000; wdata = 32'h55; wstrb = 4'h1;
      awvalid = 1; wvalid = 1; smp();
      n_chk++;
      if (awready3 !== 1'b1) begin
         n_fail++;
         $display("FAIL dec_wr_accept: got %b want 1", awready3);
      end
      sb.push_back({1'b1, 2'b11, 32'h0});
      step(); awvalid = 0; wvalid = 0; bready = 1; smp();
      n_chk++;
      if (avalid3 !== 3'b000 || bvalid3 !== 1'b1) begin
         n_fail++;
         $display("FAIL dec_wr_direct: got av=%b bv=%b want 000 1",
                  avalid3, bvalid3);
      end
      if (bvalid3 && bready && sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (!e.wr || bresp3 !== e.resp) begin
            n_fail++;
            $display("FAIL dec_wr_resp: got %b want %b", bresp3, e.resp);
         end
      end
      step();
      apply_reset();
   endtask

   task automatic test_timeout();
      exp_t e;
      int cnt_av;
      int n_tmo;
      cnt_av = 0;
      n_tmo = 0;
      apply_reset();
      awaddr = 32'h0000_0008; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
      awvalid = 1; wvalid = 1;
      smp();
      n_chk++;
      if (awready !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_accept: got %b want 1", awready);
      end
      sb.push_back({1'b1, 2'b10, 32'h0});
      step(); awvalid = 0; wvalid = 0;
      for (int i = 0; i < 40; i++) begin
         smp();
         if (avalid === 4'b0001) cnt_av++;
         if (tmo === 1'b1) n_tmo++;
         if (bvalid === 1'b1) break;
         step();
      end
      n_chk++;
      if (bvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_bound: got bv=%b want 1 within 40 cycles", bvalid);
      end
      n_chk++;
      if (cnt_av != 15) begin
         n_fail++;
         $display("FAIL tmo_avalid_len: got %0d want 15", cnt_av);
      end
      n_chk++;
      if (n_tmo != 1) begin
         n_fail++;
         $display("FAIL tmo_pulse: got %0d want 1", n_tmo);
      end
      step(); iready = '1; irvalid = '1; smp();
      n_chk++;
      if (avalid !== 4'b0000 || bvalid !== 1'b1 || tmo !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_late_ready: got av=%b bv=%b t=%b want 0000 1 0",
                  avalid, bvalid, tmo);
      end
      step(); bready = 1; smp();
      if (bvalid && bready && sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (!e.wr || bresp !== e.resp) begin
            n_fail++;
            $display("FAIL tmo_bresp: got %b want %b", bresp, e.resp);
         end
      end
      step(); bready = 0; smp();
      n_chk++;
      if (bvalid !== 1'b0 || avalid !== 4'b0000) begin
         n_fail++;
         $display("FAIL tmo_idle: got bv=%b av=%b want 0 0000", bvalid, avalid);
      end
      step(); iready = 0; irvalid = 0;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      apply_reset();
      iready = '1; irvalid = 4'b0001; irdata = '0;
      irdata[0 +: DW] = 32'hCAFE_F00D;
      awaddr = 32'h2000_0004; wdata = 32'h0000_00A5; wstrb = 4'h3;
      awvalid = 1; wvalid = 1;
      araddr = 32'h0000_0020; arvalid = 1;
      smp();
      n_chk++;
      if ({awready, arready} !== 2'b10) begin
         n_fail++;
         $display("FAIL rr_first: got %b want 10", {awready, arready});
      end
      sb.push_back({1'b1, 2'b00, 32'h0});
      step(); awaddr = 32'h0000_0040; wdata = 32'h5A5A_5A5A; wstrb = 4'hC;
      smp();
      n_chk++;
      if (avalid !== 4'b0100 || iwstrb !== 4'h3 || iaddr !== 32'h2000_0004) begin
         n_fail++;
         $display("FAIL rr_wr_iob: got av=%b s=%h a=%h want 0100 3 20000004",
                  avalid, iwstrb, iaddr);
      end
      step(); bready = 1; smp();
      if (bvalid && bready && sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (!e.wr || bresp !== e.resp) begin
            n_fail++;
            $display("FAIL rr_wr_resp: got %b want %b", bresp, e.resp);
         end
      end
      step(); bready = 0; smp();
      n_chk++;
      if ({awready, arready} !== 2'b01) begin
         n_fail++;
         $display("FAIL rr_second: got %b want 01", {awready, arready});
      end
      sb.push_back({1'b0, 2'b00, 32'hCAFE_F00D});
      step(); arvalid = 0; smp();
      n_chk++;
      if (avalid !== 4'b0001 || iwstrb !== 4'h0) begin
         n_fail++;
         $display("FAIL rr_rd_iob: got av=%b s=%h want 0001 0", avalid, iwstrb);
      end
      step(); smp();
      n_chk++;
      if (rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_rd_early: got rv=%b want 0", rvalid);
      end
      step(); rready = 1; smp();
      n_chk++;
      if (rvalid !== 1'b1 || awready !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_rd_lat3: got rv=%b aw=%b want 1 0", rvalid, awready);
      end
      if (rvalid && rready && sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (e.wr || rresp !== e.resp || rdata !== e.data) begin
            n_fail++;
            $display("FAIL rr_rd_resp: got %b %h want %b %h",
                     rresp, rdata, e.resp, e.data);
         end
      end
      step(); rready = 0; smp();
      n_chk++;
      if (awready !== 1'b1) begin
         n_fail++;
         $display("FAIL rr_third: got aw=%b want 1", awready);
      end
      sb.push_back({1'b1, 2'b00, 32'h0});
      step(); awvalid = 0; wvalid = 0; smp();
      n_chk++;
      if (avalid !== 4'b0001 || iwdata !== 32'h5A5A_5A5A || iwstrb !== 4'hC) begin
         n_fail++;
         $display("FAIL rr_wr2_iob: got av=%b d=%h s=%h want 0001 5a5a5a5a c",
                  avalid, iwdata, iwstrb);
      end
      step(); bready = 1; smp();
      if (bvalid && bready && sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (!e.wr || bresp !== e.resp) begin
            n_fail++;
            $display("FAIL rr_wr2_resp: got %b want %b", bresp, e.resp);
         end
      end
      step(); bready = 0; iready = 0; irvalid = 0;
   endtask

   task automatic test_reset_midflight();
      int nrv;
      nrv = 0;
      araddr = 32'h1000_0000; arvalid = 1; iready = 4'b0010;
      smp();
      n_chk++;
      if (arready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_accept: got %b want 1", arready);
      end
      step(); arvalid = 0; smp();
      step(); rst_n = 0; iready = 0; smp();
      n_chk++;
      if (avalid !== 4'b0000 || rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rd_wait: got av=%b rv=%b want 0000 0", avalid, rvalid);
      end
      step(); rst_n = 1; irvalid = 4'b0010;
      irdata[DW +: DW] = 32'h7777_7777; rready = 1; smp();
      n_chk++;
      if ({awready, wready, bvalid, bresp, arready, rvalid, rresp,
           rdata, avalid, iaddr, iwdata, iwstrb, tmo} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_outs: got rv=%b d=%h a=%h want all 0",
                  rvalid, rdata, iaddr);
      end
      for (int i = 0; i < 4; i++) begin
         step(); smp();
         if (rvalid === 1'b1) nrv++;
      end
      n_chk++;
      if (nrv != 0) begin
         n_fail++;
         $display("FAIL mid_no_rvalid: got %0d rvalid cycles want 0", nrv);
      end
      step(); idle_inputs();
   endtask

   task automatic test_cke();
      exp_t e;
      awaddr = 32'h0000_0000; wdata = 32'h1; wstrb = 4'h1;
      awvalid = 1; wvalid = 1; cke = 0;
      smp();
      n_chk++;
      if (awready !== 1'b0) begin
         n_fail++;
         $display("FAIL cke_block: got aw=%b want 0", awready);
      end
      step(); cke = 1; smp();
      n_chk++;
      if (awready !== 1'b1) begin
         n_fail++;
         $display("FAIL cke_accept: got aw=%b want 1", awready);
      end
      sb.push_back({1'b1, 2'b00, 32'h0});
      step(); awvalid = 0; wvalid = 0; cke = 0; iready = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         smp();
         n_chk++;
         if (avalid !== 4'b0001 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL cke_hold%0d: got av=%b bv=%b want 0001 0",
                     i, avalid, bvalid);
         end
         step();
      end
      cke = 1; smp();
      step(); bready = 1; smp();
      n_chk++;
      if (bvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL cke_resume: got bv=%b want 1", bvalid);
      end
      if (bvalid && bready && sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (!e.wr || bresp !== e.resp) begin
            n_fail++;
            $display("FAIL cke_bresp: got %b want %b", bresp, e.resp);
         end
      end
      step(); bready = 0; iready = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_decerr();
      test_timeout();
      test_back_to_back();
      test_reset_midflight();
      test_cke();
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
